// File: rtl/pong_pkg.sv
// Shared encodings and screen constants for the Pong datapath blocks.
package pong_pkg;

  localparam logic [2:0] ST_IDLE     = 3'b000;
  localparam logic [2:0] ST_SERVE    = 3'b001;
  localparam logic [2:0] ST_PLAY     = 3'b010;
  localparam logic [2:0] ST_POINT    = 3'b011;
  localparam logic [2:0] ST_GAMEOVER = 3'b100;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int BALL_HOME_X = 320;
  localparam int BALL_HOME_Y = 240;

  localparam int DEF_LEFT_GOAL  = 10;
  localparam int DEF_RIGHT_GOAL = 629;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/pong_game_ctrl_edge_sync.sv
// Two-flop synchronizer followed by a registered single-cycle edge pulse.
module edge_sync #(
  parameter bit FALLING = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic s0, s1, s1_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0    <= 1'b0;
      s1    <= 1'b0;
      s1_d  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s0    <= din;
      s1    <= s0;
      s1_d  <= s1;
      pulse <= FALLING ? (s1_d & ~s1) : (s1 & ~s1_d);
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serve / play / point / game-over FSM, frame counter, scores.
//   state    | meaning
//   IDLE     | waiting for start, ball held at home
//   SERVE    | ball held at home for SERVE_FRAMES ticks
//   PLAY     | ball moving, goals checked on each frame tick
//   POINT    | ball frozen at goal for POINT_FRAMES ticks
//   GAMEOVER | a player reached WIN_SCORE, scores held until start
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 120,
  parameter int LEFT_GOAL    = DEF_LEFT_GOAL,
  parameter int RIGHT_GOAL   = DEF_RIGHT_GOAL
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       start,
  input  logic [9:0] ball_x,
  output logic       ball_reset,
  output logic       ball_enable,
  output logic       serve_left,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over,
  output logic [2:0] state
);

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
  localparam logic [9:0] LEFT_LIM   = 10'(LEFT_GOAL);
  localparam logic [9:0] RIGHT_LIM  = 10'(RIGHT_GOAL);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);

  logic       frame_tick, start_pulse;
  logic [7:0] fcnt, fcnt_n;
  logic [2:0] state_n;
  logic [3:0] score1_n, score2_n;
  logic       serve_left_n;

  edge_sync #(.FALLING(1'b1)) u_vsync_sync (
    .clk   (clk),
    .reset (reset),
    .din   (vsync),
    .pulse (frame_tick)
  );

  edge_sync #(.FALLING(1'b0)) u_start_sync (
    .clk   (clk),
    .reset (reset),
    .din   (start),
    .pulse (start_pulse)
  );

  always_comb begin
    state_n      = state;
    fcnt_n       = fcnt;
    score1_n     = score1;
    score2_n     = score2;
    serve_left_n = serve_left;
    case (state)
      ST_IDLE, ST_GAMEOVER: begin
        // start wins over a coincident frame tick
        if (start_pulse) begin
          state_n      = ST_SERVE;
          fcnt_n       = 8'd0;
          score1_n     = 4'd0;
          score2_n     = 4'd0;
          serve_left_n = 1'b0;
        end else if (frame_tick) begin
          fcnt_n = fcnt + 8'd1;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (fcnt == SERVE_LAST) begin
            state_n = ST_PLAY;
            fcnt_n  = 8'd0;
          end else begin
            fcnt_n = fcnt + 8'd1;
          end
        end
      end
      ST_PLAY: begin
        if (frame_tick) begin
          if (ball_x < LEFT_LIM) begin
            score2_n     = sat_inc(score2);
            serve_left_n = 1'b1;
            state_n      = ST_POINT;
            fcnt_n       = 8'd0;
          end else if (ball_x > RIGHT_LIM) begin
            score1_n     = sat_inc(score1);
            serve_left_n = 1'b0;
            state_n      = ST_POINT;
            fcnt_n       = 8'd0;
          end else begin
            fcnt_n = fcnt + 8'd1;
          end
        end
      end
      ST_POINT: begin
        if (frame_tick) begin
          if (fcnt == POINT_LAST) begin
            state_n = (score1 == WIN || score2 == WIN) ? ST_GAMEOVER : ST_SERVE;
            fcnt_n  = 8'd0;
          end else begin
            fcnt_n = fcnt + 8'd1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        fcnt_n  = 8'd0;
      end
    endcase
  end

  // Outputs decoded from the next state so they change with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      fcnt        <= 8'd0;
      score1      <= 4'd0;
      score2      <= 4'd0;
      serve_left  <= 1'b0;
      ball_reset  <= 1'b1;
      ball_enable <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_n;
      fcnt        <= fcnt_n;
      score1      <= score1_n;
      score2      <= score2_n;
      serve_left  <= serve_left_n;
      ball_reset  <= (state_n == ST_IDLE) || (state_n == ST_SERVE) || (state_n == ST_GAMEOVER);
      ball_enable <= (state_n == ST_PLAY);
      game_over   <= (state_n == ST_GAMEOVER);
    end
  end

endmodule
